// File: rtl/fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_unit_arbiter
// Purpose  : Round-robin arbiter that shares one variable-latency float unit
//            (start/done handshake) among NREQ requesters. It latches the
//            winner's operands, sequences the unit's enable, start and done
//            signals, and returns the result with a one-hot response pulse.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid/a/b     - per-requester request and packed operands
//            req_ready         - one-hot accept pulse (ISSUE cycle)
//            rsp_valid         - one-hot result pulse (RESP cycle)
//            rsp_data          - shared result word, held until next capture
//            unit_rst_n        - float unit enable (low clears the unit)
//            unit_start        - one-cycle start pulse to the unit
//            unit_a, unit_b    - latched operands to the unit
//            unit_result/done  - unit result and completion
//            busy              - high whenever the FSM is not in IDLE
//            timeout_err       - sticky watchdog flag
// Options  : define FP_UNIT_ARB_TIMEOUT_EN to build the WAIT watchdog that
//            returns a quiet NaN after TO_CYCLES cycles without unit_done.
// Revision : 1.0 - initial release
// ============================================================================
module fp_unit_arbiter #(
  parameter int S         = 32,
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [S*NREQ-1:0] req_a,
  input  logic [S*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [S-1:0]      rsp_data,
  output logic              unit_rst_n,
  output logic              unit_start,
  output logic [S-1:0]      unit_a,
  output logic [S-1:0]      unit_b,
  input  logic [S-1:0]      unit_result,
  input  logic              unit_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] win_idx;
  logic          win_found;

  // (base + off) mod NREQ for off < NREQ; one conditional subtract suffices.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First valid requester scanning upward from the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_valid[wrap_add(ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr, k);
      end
    end
  end

`ifdef FP_UNIT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
`else
  // Watchdog not built: the limit has no effect and the flag is constant.
  logic unused_cfg;
  assign unused_cfg  = ^TO_CYCLES;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      unit_start <= 1'b0;
      unit_rst_n <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
      busy       <= 1'b0;
`ifdef FP_UNIT_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      req_ready  <= '0;
      rsp_valid  <= '0;
      unit_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt        <= win_idx;
            unit_a     <= req_a[S*win_idx +: S];
            unit_b     <= req_b[S*win_idx +: S];
            req_ready  <= onehot(win_idx);
            unit_start <= 1'b1;
            unit_rst_n <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // unit_done in this cycle is deliberately not looked at.
          state <= WAIT;
`ifdef FP_UNIT_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          if (unit_done) begin
            rsp_data   <= unit_result;
            rsp_valid  <= onehot(gnt);
            unit_rst_n <= 1'b0;
            state      <= RESP;
          end
`ifdef FP_UNIT_ARB_TIMEOUT_EN
          // Count would reach TO_CYCLES at this edge: give up with a qNaN.
          else if (wd_cnt == CW'(TO_CYCLES - 1)) begin
            rsp_data    <= S'(32'h7FC0_0000);
            rsp_valid   <= onehot(gnt);
            unit_rst_n  <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          ptr   <= wrap_add(gnt, 1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_unit_arbiter
// Purpose  : Self-checking bench for fp_unit_arbiter: directed vector table,
//            hand-written corner sequences and a randomized phase, all checked
//            against a transaction-level reference model with a float unit
//            model of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_unit_arbiter;
  localparam int S     = 32;
  localparam int NREQ  = 4;
  localparam int TO    = 64;
  localparam int NEVER = 2147483647;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [S*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [S-1:0]      rsp_data, unit_a, unit_b, unit_result;
  logic              unit_rst_n, unit_start, unit_done, busy, timeout_err;

  always #5 clk = ~clk;

  fp_unit_arbiter #(.S(S), .NREQ(NREQ), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .unit_rst_n(unit_rst_n), .unit_start(unit_start),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_result(unit_result), .unit_done(unit_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- float unit model ----------------
  logic        auto_en = 1'b1;
  logic        rand_lat = 1'b0;
  logic        use_fixed = 1'b0;
  logic        force_done = 1'b0;
  logic [31:0] fixed_res = '0;
  int          lat = 5;
  int          done_cyc = NEVER;

  function automatic logic [31:0] op_f(logic [31:0] a, logic [31:0] b);
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
  endfunction

  // Done is raised lat+1 cycles after the start cycle.
  initial begin
    unit_done   = 1'b0;
    unit_result = '0;
    forever begin
      @(posedge clk); #2;
      if (unit_start === 1'b1) begin
        if (rand_lat) lat = int'($urandom_range(0, 6));
        done_cyc = cyc + lat + 1;
      end
      unit_done   = force_done || (auto_en && cyc == done_cyc);
      unit_result = use_fixed ? fixed_res : op_f(unit_a, unit_b);
    end
  end

  // ---------------- reference model (event timestamps) ----------------
  logic        model_ok = 1'b0, inflight = 1'b0;
  int          grant_due = NEVER, rsp_due = NEVER, ptr_m = 0, g_m = 0;
  logic [31:0] m_ua = '0, m_ub = '0, m_data = '0, p_ua = '0, p_ub = '0, p_data = '0;
  logic        m_terr = 1'b0, p_terr = 1'b0;

  always @(negedge clk) begin
    if (model_ok) begin
      if (inflight && cyc == grant_due) begin m_ua = p_ua; m_ub = p_ub; end
      if (inflight && cyc == rsp_due) begin m_data = p_data; m_terr = m_terr | p_terr; end
      chk("req_ready", 64'(req_ready), (inflight && cyc == grant_due) ? (64'd1 << g_m) : 64'd0);
      chk("unit_start", 64'(unit_start), 64'(inflight && cyc == grant_due));
      chk("rsp_valid", 64'(rsp_valid), (inflight && cyc == rsp_due) ? (64'd1 << g_m) : 64'd0);
      chk("busy", 64'(busy), 64'(inflight && cyc >= grant_due));
      chk("unit_rst_n", 64'(unit_rst_n), 64'(inflight && cyc >= grant_due && cyc < rsp_due));
      chk("unit_a", 64'(unit_a), 64'(m_ua));
      chk("unit_b", 64'(unit_b), 64'(m_ub));
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
      chk("timeout_err", 64'(timeout_err), 64'(m_terr));
      if (inflight && cyc == rsp_due) begin
        inflight  = 1'b0;
        ptr_m     = (g_m + 1) % NREQ;
        rsp_due   = NEVER;
        grant_due = NEVER;
      end else if (inflight && cyc > grant_due && rsp_due == NEVER) begin
        if (unit_done === 1'b1) begin
          rsp_due = cyc + 1; p_data = unit_result; p_terr = 1'b0;
        end
`ifdef FP_UNIT_ARB_TIMEOUT_EN
        else if (cyc == grant_due + TO) begin
          rsp_due = cyc + 1; p_data = 32'h7FC0_0000; p_terr = 1'b1;
        end
`endif
      end else if (!inflight && req_valid != '0) begin
        for (int k = 0; k < NREQ; k++)
          if (!inflight && req_valid[(ptr_m + k) % NREQ]) begin
            g_m = (ptr_m + k) % NREQ; inflight = 1'b1;
          end
        grant_due = cyc + 1;
        p_ua = req_a[32*g_m +: 32];
        p_ub = req_b[32*g_m +: 32];
      end
    end
    if (rst === 1'b1) begin
      model_ok = 1'b1; inflight = 1'b0; ptr_m = 0; g_m = 0;
      grant_due = NEVER; rsp_due = NEVER;
      m_ua = '0; m_ub = '0; m_data = '0; m_terr = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic [3:0]  vld;
    logic [31:0] a, b, res;
    int          lat;
    int          exp_g;
  } vec_t;
  vec_t tbl[12];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input string nm, input int budget);
    bit got = 0;
    for (int n = 0; n < budget && !got; n++) begin
      tick();
      if (req_ready != '0) got = 1;
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  task automatic drain();
    req_valid = '0;
    for (int n = 0; n < 40 && busy; n++) tick();
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    bit got = 0;
    req_valid = v.vld;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = v.a;
      req_b[32*i +: 32] = v.b;
    end
    lat = v.lat; use_fixed = 1'b1; fixed_res = v.res;
    wait_grant("vec_grant_seen", 20);
    chk("vec_grant", 64'(req_ready), 64'd1 << v.exp_g);
    chk("vec_start", 64'(unit_start), 64'd1);
    chk("vec_unit_a", 64'(unit_a), 64'(v.a));
    chk("vec_unit_b", 64'(unit_b), 64'(v.b));
    t0 = cyc;
    req_valid = '0;
    for (int n = 0; n < v.lat + 10 && !got; n++) begin
      tick();
      if (rsp_valid != '0) got = 1;
    end
    chk("vec_rsp_seen", 64'(got), 64'd1);
    chk("vec_rsp_valid", 64'(rsp_valid), 64'd1 << v.exp_g);
    chk("vec_rsp_data", 64'(rsp_data), 64'(v.res));
    chk("vec_latency", 64'(cyc - t0), 64'(v.lat + 2));
    tick();
    chk("vec_busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int prev, nr, cnt, t0, g_prev;
    logic [3:0] last_rdy;
    req_valid = '0; req_a = '0; req_b = '0;

    tbl[0]  = '{4'b0010, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 1};
    tbl[1]  = '{4'b1111, 32'h4120_0000, 32'h3F00_0000, 32'h4128_0000, 0, 2};
    tbl[2]  = '{4'b1111, 32'hC000_0000, 32'h4000_0000, 32'h0000_0000, 3, 3};
    tbl[3]  = '{4'b1111, 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF, 1, 0};
    tbl[4]  = '{4'b1111, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 6, 1};
    tbl[5]  = '{4'b1001, 32'h4049_0FDB, 32'h402D_F854, 32'h40C5_F680, 2, 3};
    tbl[6]  = '{4'b1001, 32'h7F7F_FFFF, 32'h0080_0000, 32'h7F80_0000, 4, 0};
    tbl[7]  = '{4'b0001, 32'h0000_0001, 32'h8000_0001, 32'h1234_5678, 0, 0};
    tbl[8]  = '{4'b0100, 32'hAAAA_5555, 32'h5555_AAAA, 32'h8765_4321, 5, 2};
    tbl[9]  = '{4'b0011, 32'h3DCC_CCCD, 32'h3E4C_CCCD, 32'h3E99_999A, 2, 0};
    tbl[10] = '{4'b1000, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, 1, 3};
    tbl[11] = '{4'b0110, 32'h4480_0000, 32'h4200_0000, 32'h4484_0000, 3, 1};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_unit_rst_n", 64'(unit_rst_n), 64'd0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);
    use_fixed = 1'b0;

    // Continuous 1111: strict rotation; after grant to 2 keep only 0 and 3.
    lat = 1; req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'h100 + i; req_b[32*i +: 32] = 32'h200 + i;
    end
    g_prev = -1;
    for (int k = 0; k < 8; k++) begin
      wait_grant("rr_grant_seen", 20);
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin
          if (g_prev >= 0) chk("rr_rotation", 64'(i), 64'((g_prev + 1) % NREQ));
          g_prev = i;
        end
      if (req_ready == 4'b0100) break;
    end
    req_valid = 4'b1001;
    wait_grant("rr_after2_seen", 20);
    chk("rr_after2_first", 64'(req_ready), 64'b1000);
    wait_grant("rr_after2_seen2", 20);
    chk("rr_after2_second", 64'(req_ready), 64'b0001);
    drain();

    // Back-to-back from requester 2 with latency 3: one response per 7 cycles.
    lat = 3; req_valid = 4'b0100; prev = -1; nr = 0;
    for (int n = 0; n < 60 && nr < 4; n++) begin
      tick();
      if (rsp_valid != '0) begin
        chk("b2b_rsp", 64'(rsp_valid), 64'b0100);
        if (prev >= 0) chk("b2b_interval", 64'(cyc - prev), 64'd7);
        prev = cyc; nr++;
      end
    end
    chk("b2b_count", 64'(nr), 64'd4);
    drain();

    // Spurious done in IDLE and ISSUE; held done gives one response.
    auto_en = 1'b0;
    force_done = 1'b1; tick(); force_done = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_done_rsp", 64'(rsp_valid), 64'd0);
      chk("idle_done_busy", 64'(busy), 64'd0);
    end
    req_valid = 4'b0001;
    wait_grant("sp_grant_seen", 20);
    req_valid = '0;
    force_done = 1'b1; tick(); force_done = 1'b0;
    repeat (4) begin
      tick();
      chk("issue_done_rsp", 64'(rsp_valid), 64'd0);
      chk("issue_done_busy", 64'(busy), 64'd1);
    end
    force_done = 1'b1; cnt = 0;
    repeat (3) begin tick(); if (rsp_valid != '0) cnt++; end
    force_done = 1'b0;
    repeat (3) begin tick(); if (rsp_valid != '0) cnt++; end
    chk("held_done_single_rsp", 64'(cnt), 64'd1);
    auto_en = 1'b1;
    drain();

    // Reset during WAIT abandons the operation; stale done is ignored.
    lat = 20; req_valid = 4'b0100;
    wait_grant("rw_grant_seen", 20);
    req_valid = '0;
    repeat (3) tick();
    rst = 1'b1; tick();
    chk("rw_req_ready", 64'(req_ready), 64'd0);
    chk("rw_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rw_rsp_data", 64'(rsp_data), 64'd0);
    chk("rw_unit_start", 64'(unit_start), 64'd0);
    chk("rw_unit_rst_n", 64'(unit_rst_n), 64'd0);
    chk("rw_unit_a", 64'(unit_a), 64'd0);
    chk("rw_unit_b", 64'(unit_b), 64'd0);
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_timeout_err", 64'(timeout_err), 64'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (25) begin tick(); if (rsp_valid != '0 || busy) cnt++; end
    chk("rw_stale_done_ignored", 64'(cnt), 64'd0);
    lat = 2; req_valid = 4'b1010;
    wait_grant("rw_new_grant_seen", 20);
    chk("rw_new_grant_lowest", 64'(req_ready), 64'b0010);
    drain();

    // Unit that never completes.
    auto_en = 1'b0; req_valid = 4'b0001;
    wait_grant("wd_grant_seen", 20);
    t0 = cyc; req_valid = '0;
`ifdef FP_UNIT_ARB_TIMEOUT_EN
    nr = 0;
    for (int n = 0; n < 100 && nr == 0; n++) begin
      tick();
      if (rsp_valid != '0) nr = 1;
    end
    chk("wd_rsp_seen", 64'(nr), 64'd1);
    chk("wd_latency", 64'(cyc - t0), 64'd65);
    chk("wd_rsp_data", 64'(rsp_data), 64'h7FC0_0000);
    chk("wd_flag", 64'(timeout_err), 64'd1);
    repeat (10) tick();
    chk("wd_flag_sticky", 64'(timeout_err), 64'd1);
    pulse_rst();
    chk("wd_flag_cleared", 64'(timeout_err), 64'd0);
`else
    repeat (1000) tick();
    chk("wd_busy_forever", 64'(busy), 64'd1);
    chk("wd_flag_zero", 64'(timeout_err), 64'd0);
    pulse_rst();
    chk("wd_busy_after_rst", 64'(busy), 64'd0);
`endif
    auto_en = 1'b1;

    // Randomized traffic checked by the reference model.
    rand_lat = 1'b1; last_rdy = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_rdy[i] || (!req_valid[i] && $urandom_range(0, 3) == 0)) begin
          req_valid[i] = last_rdy[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          req_a[32*i +: 32] = $urandom;
          req_b[32*i +: 32] = $urandom;
        end
      end
      last_rdy = req_ready;
      tick();
    end
    rand_lat = 1'b0;
    drain();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
